// File: rtl/frogger_pkg.sv
// Shared constants and types for the Frogger road-traffic engine.
// Holds the grid geometry, the initial car patterns and per-lane speed divisors,
// and the table that maps a speed level to a tick-period shift.
package frogger_pkg;

  localparam int NUM_COLS  = 14;
  localparam int START_ROW = 14;
  localparam int GOAL_ROW  = 0;

  typedef logic [NUM_COLS-1:0] lane_t;

  // Index 0 is the leftmost entry (lane 0 sits at the top of the road band).
  localparam logic [0:5][NUM_COLS-1:0] LANE_INIT = {
    14'h0003, 14'h0618, 14'h0111, 14'h3000, 14'h0C0C, 14'h0421
  };

  // A lane advances once every LANE_DIV[k] traffic ticks.
  localparam logic [0:5][1:0] LANE_DIV = {2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};

  // Tick period at level L is BASE_TICK_CYCLES >> LEVEL_SHIFT[L].
  localparam logic [0:3][1:0] LEVEL_SHIFT = {2'd0, 2'd1, 2'd2, 2'd3};

  // Speed level = min(score / 4, 3).
  function automatic logic [1:0] score_to_level(input logic [6:0] score);
    logic [4:0] quarter;
    quarter = score[6:2];
    return (quarter > 5'd3) ? 2'd3 : quarter[1:0];
  endfunction

endpackage

// File: rtl/frogger_hazard_ctrl_if.sv
// Signal bundle between the game controller/renderer and the hazard engine.
//  i_Frogger_X/Y    frog cell from frogger_ctrl
//  i_Score          current score (selects speed level)
//  i_Col/Row_Count_Div  renderer cell being drawn
//  o_Collided       one-cycle collision pulse
//  o_Car_Pixel      car present at the renderer cell
//  o_Level          current speed level
// master = game/renderer side, slave = hazard engine.
interface frogger_hazard_ctrl_if;

  logic [5:0] i_Frogger_X;
  logic [5:0] i_Frogger_Y;
  logic [6:0] i_Score;
  logic [5:0] i_Col_Count_Div;
  logic [5:0] i_Row_Count_Div;
  logic       o_Collided;
  logic       o_Car_Pixel;
  logic [1:0] o_Level;

  modport master (
    output i_Frogger_X, i_Frogger_Y, i_Score, i_Col_Count_Div, i_Row_Count_Div,
    input  o_Collided, o_Car_Pixel, o_Level
  );

  modport slave (
    input  i_Frogger_X, i_Frogger_Y, i_Score, i_Col_Count_Div, i_Row_Count_Div,
    output o_Collided, o_Car_Pixel, o_Level
  );

endinterface

// File: rtl/frogger_lane_shifter.sv
// One road lane: a circular car pattern that rotates by one column every
// DIV-th traffic tick.
//  i_Clk      system clock
//  i_Reset    asynchronous active-high reset (pattern <- INIT, divider <- 0)
//  i_Tick     one-cycle traffic tick
//  o_Pattern  current pattern, bit n = column n
// SHIFT_UP=1 moves cars toward higher columns (bit 13 wraps to bit 0);
// SHIFT_UP=0 moves them toward lower columns (bit 0 wraps to bit 13).
module frogger_lane_shifter
  import frogger_pkg::*;
#(
  parameter lane_t INIT     = '0,
  parameter int    DIV      = 1,
  parameter bit    SHIFT_UP = 1'b1
) (
  input  logic  i_Clk,
  input  logic  i_Reset,
  input  logic  i_Tick,
  output lane_t o_Pattern
);

  localparam int DivW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DivW-1:0] r_div_cnt;
  lane_t           r_pattern;
  lane_t           w_rotated;
  logic            w_step;

  assign w_step = i_Tick && (r_div_cnt == DivW'(DIV - 1));

  always_comb begin
    if (SHIFT_UP) begin
      w_rotated = {r_pattern[NUM_COLS-2:0], r_pattern[NUM_COLS-1]};
    end else begin
      w_rotated = {r_pattern[0], r_pattern[NUM_COLS-1:1]};
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_div_cnt <= '0;
      r_pattern <= INIT;
    end else if (i_Tick) begin
      r_div_cnt <= w_step ? '0 : r_div_cnt + 1'b1;
      if (w_step) begin
        r_pattern <= w_rotated;
      end
    end
  end

  assign o_Pattern = r_pattern;

endmodule

// File: rtl/frogger_hazard_ctrl.sv
// Road-traffic engine for Frogger: scrolls the lane car patterns, detects the
// frog being hit and emits a single collision pulse per life, and serves a
// per-cell car bit to the VGA renderer. Traffic speeds up with score.
//  i_Clk    system clock
//  i_Reset  asynchronous active-high reset
//  bus      frogger_hazard_ctrl_if.slave (frog position, score, renderer cell
//           in; o_Collided, o_Car_Pixel, o_Level out)
module frogger_hazard_ctrl
  import frogger_pkg::*;
#(
  parameter int BASE_TICK_CYCLES = 1_250_000,
  parameter int FIRST_ROAD_ROW   = 8,
  parameter int NUM_LANES        = 6
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  frogger_hazard_ctrl_if.slave  bus
);

  localparam int CntW = (BASE_TICK_CYCLES > 1) ? $clog2(BASE_TICK_CYCLES) : 1;

  logic [1:0]      r_level;
  logic [CntW-1:0] r_tick_cnt;
  logic [CntW-1:0] w_tick_limit;
  int              w_period;
  logic            w_tick;

  logic            r_armed;
  logic            r_collided;
  logic            r_car_pixel;

  lane_t           w_pattern [NUM_LANES];
  lane_t           w_frog_lane;
  logic            w_frog_on_road;
  logic            w_hit;
  lane_t           w_pix_lane;
  logic            w_pix_on_road;
  logic            w_pix_bit;

  // ---------------------------------------------------------------- speed/tick
  always_comb begin
    w_period = BASE_TICK_CYCLES >> LEVEL_SHIFT[r_level];
    // Small bases can shift down to zero; the fastest legal rate is every clock.
    if (w_period < 1) begin
      w_period = 1;
    end
    w_tick_limit = CntW'(w_period - 1);
  end

  // >= rather than == so a level rise that leaves the count beyond the new
  // limit ticks on the next cycle instead of wrapping the counter.
  assign w_tick = (r_tick_cnt >= w_tick_limit);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_tick_cnt <= '0;
      r_level    <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_level    <= score_to_level(bus.i_Score);
    end
  end

  // --------------------------------------------------------------------- lanes
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    frogger_lane_shifter #(
      .INIT     (LANE_INIT[k]),
      .DIV      (int'(LANE_DIV[k])),
      .SHIFT_UP ((k % 2) == 0)
    ) u_lane (
      .i_Clk     (i_Clk),
      .i_Reset   (i_Reset),
      .i_Tick    (w_tick),
      .o_Pattern (w_pattern[k])
    );
  end

  // ------------------------------------------------------------ lane selection
  always_comb begin
    w_frog_lane    = '0;
    w_frog_on_road = 1'b0;
    w_pix_lane     = '0;
    w_pix_on_road  = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (bus.i_Frogger_Y == 6'(FIRST_ROAD_ROW + k)) begin
        w_frog_lane    = w_pattern[k];
        w_frog_on_road = 1'b1;
      end
      if (bus.i_Row_Count_Div == 6'(FIRST_ROAD_ROW + k)) begin
        w_pix_lane    = w_pattern[k];
        w_pix_on_road = 1'b1;
      end
    end
  end

  // Patterns are read before this edge's shift lands, so a coinciding tick
  // does not move the car out from under (or onto) the frog this cycle.
  assign w_hit = w_frog_on_road && (bus.i_Frogger_X < 6'(NUM_COLS)) &&
                 w_frog_lane[bus.i_Frogger_X[3:0]];

  assign w_pix_bit = w_pix_on_road && (bus.i_Col_Count_Div < 6'(NUM_COLS)) &&
                     w_pix_lane[bus.i_Col_Count_Div[3:0]];

  // ---------------------------------------------------------- collision / arm
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_armed     <= 1'b1;
      r_collided  <= 1'b0;
      r_car_pixel <= 1'b0;
    end else begin
      r_collided  <= w_hit && r_armed;
      r_car_pixel <= w_pix_bit;
      // Disarm on the pulse; re-arm only once the frog is back at the start row.
      if (w_hit && r_armed) begin
        r_armed <= 1'b0;
      end else if ((bus.i_Frogger_Y == 6'(START_ROW)) && !w_hit) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign bus.o_Collided  = r_collided;
  assign bus.o_Car_Pixel = r_car_pixel;
  assign bus.o_Level     = r_level;

endmodule
